// File: rtl/hardcloud_kernel_pkg.sv
// Shared types and default widths for the hardcloud kernel sequencer.
package hardcloud_kernel_pkg;

  localparam int unsigned HK_ADDR_WIDTH  = 64;
  localparam int unsigned HK_SIZE_WIDTH  = 32;
  localparam int unsigned HK_PASS_WIDTH  = 32;
  localparam int unsigned HK_CYCLE_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/hardcloud_done_join.sv
// Sticky two-input completion join: both_done holds once each engine has reported.
module hardcloud_done_join (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic rd_done,
  input  logic wr_done,
  output logic both_done
);

  logic rd_flag;
  logic wr_flag;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_flag <= 1'b0;
      wr_flag <= 1'b0;
    end else if (clear) begin
      rd_flag <= 1'b0;
      wr_flag <= 1'b0;
    end else begin
      rd_flag <= rd_flag | rd_done;
      wr_flag <= wr_flag | wr_done;
    end
  end

  // Same-cycle completions count without waiting for the flags to settle.
  assign both_done = (rd_flag | rd_done) & (wr_flag | wr_done);

endmodule

// File: rtl/hardcloud_kernel_ctrl.sv
// Kernel sequencer: runs scalar01 passes of paired read/write engine launches.
// Optional HARDCLOUD_KERNEL_CYCLE_COUNT_EN adds a 64-bit busy-cycle counter output.
module hardcloud_kernel_ctrl
  import hardcloud_kernel_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = HK_ADDR_WIDTH,
  parameter int unsigned C_SIZE_WIDTH = HK_SIZE_WIDTH,
  parameter int unsigned C_PASS_WIDTH = HK_PASS_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    ap_start,
  output logic                    ap_idle,
  output logic                    ap_done,
  input  logic [C_SIZE_WIDTH-1:0] scalar00,
  input  logic [C_PASS_WIDTH-1:0] scalar01,
  input  logic [C_ADDR_WIDTH-1:0] axi00_ptr0,
  input  logic [C_ADDR_WIDTH-1:0] axi01_ptr0,
  output logic                    rd_start,
  output logic [C_ADDR_WIDTH-1:0] rd_addr,
  output logic [C_SIZE_WIDTH-1:0] rd_size,
  input  logic                    rd_done,
  output logic                    wr_start,
  output logic [C_ADDR_WIDTH-1:0] wr_addr,
  output logic [C_SIZE_WIDTH-1:0] wr_size,
  input  logic                    wr_done
`ifdef HARDCLOUD_KERNEL_CYCLE_COUNT_EN
  ,
  output logic [HK_CYCLE_WIDTH-1:0] cycle_count
`endif
);

  state_e                  state, state_d;
  logic                    ap_start_q;
  logic [C_SIZE_WIDTH-1:0] size_q, size_d;
  logic [C_PASS_WIDTH-1:0] passes_q, passes_d;
  logic [C_PASS_WIDTH-1:0] pass_cnt, pass_cnt_d;
  logic [C_ADDR_WIDTH-1:0] rd_addr_d, wr_addr_d;
  logic                    start_edge_c;
  logic                    join_clear_c;
  logic                    both_done_c;
  logic                    in_wait_c;

  assign start_edge_c = ap_start & ~ap_start_q & (state == IDLE);
  assign in_wait_c    = (state == WAIT);

  hardcloud_done_join u_join (
    .aclk      (aclk),
    .areset    (areset),
    .clear     (join_clear_c),
    .rd_done   (rd_done & in_wait_c),
    .wr_done   (wr_done & in_wait_c),
    .both_done (both_done_c)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d      = state;
    size_d       = size_q;
    passes_d     = passes_q;
    pass_cnt_d   = pass_cnt;
    rd_addr_d    = rd_addr;
    wr_addr_d    = wr_addr;
    join_clear_c = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge_c) begin
          size_d       = scalar00;
          passes_d     = scalar01;
          rd_addr_d    = axi00_ptr0;
          wr_addr_d    = axi01_ptr0;
          pass_cnt_d   = '0;
          join_clear_c = 1'b1;
          state_d      = ((scalar00 == '0) || (scalar01 == '0)) ? DONE : LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (both_done_c) begin
          join_clear_c = 1'b1;
          pass_cnt_d   = pass_cnt + C_PASS_WIDTH'(1);
          rd_addr_d    = rd_addr + C_ADDR_WIDTH'(size_q);
          wr_addr_d    = wr_addr + C_ADDR_WIDTH'(size_q);
          state_d      = (pass_cnt_d == passes_q) ? DONE : LAUNCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      ap_start_q <= 1'b0;
      ap_idle    <= 1'b1;
      ap_done    <= 1'b0;
      rd_start   <= 1'b0;
      wr_start   <= 1'b0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      size_q     <= '0;
      passes_q   <= '0;
      pass_cnt   <= '0;
    end else begin
      state      <= state_d;
      ap_start_q <= ap_start;
      ap_idle    <= (state_d == IDLE);
      ap_done    <= (state_d == DONE);
      rd_start   <= (state_d == LAUNCH);
      wr_start   <= (state_d == LAUNCH);
      rd_addr    <= rd_addr_d;
      wr_addr    <= wr_addr_d;
      size_q     <= size_d;
      passes_q   <= passes_d;
      pass_cnt   <= pass_cnt_d;
    end
  end

  assign rd_size = size_q;
  assign wr_size = size_q;

`ifdef HARDCLOUD_KERNEL_CYCLE_COUNT_EN
  // Busy-cycle counter, restarted by each launch and frozen in IDLE.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cycle_count <= '0;
    end else if (start_edge_c) begin
      cycle_count <= '0;
    end else if (state != IDLE) begin
      cycle_count <= cycle_count + HK_CYCLE_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hardcloud_kernel_ctrl.sv
// Scoreboard bench for hardcloud_kernel_ctrl with a delay-programmable engine responder.
module tb_hardcloud_kernel_ctrl;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_idle, ap_done;
  logic [31:0] scalar00 = '0;
  logic [31:0] scalar01 = '0;
  logic [63:0] axi00_ptr0 = '0;
  logic [63:0] axi01_ptr0 = '0;
  logic        rd_start, wr_start;
  logic [63:0] rd_addr, wr_addr;
  logic [31:0] rd_size, wr_size;
  logic        rd_done = 1'b0;
  logic        wr_done = 1'b0;
`ifdef HARDCLOUD_KERNEL_CYCLE_COUNT_EN
  logic [63:0] cycle_count;
`endif

  hardcloud_kernel_ctrl dut (
    .aclk       (aclk),
    .areset     (areset),
    .ap_start   (ap_start),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .scalar00   (scalar00),
    .scalar01   (scalar01),
    .axi00_ptr0 (axi00_ptr0),
    .axi01_ptr0 (axi01_ptr0),
    .rd_start   (rd_start),
    .rd_addr    (rd_addr),
    .rd_size    (rd_size),
    .rd_done    (rd_done),
    .wr_start   (wr_start),
    .wr_addr    (wr_addr),
    .wr_size    (wr_size),
    .wr_done    (wr_done)
`ifdef HARDCLOUD_KERNEL_CYCLE_COUNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] rd;
    logic [63:0] wr;
    logic [31:0] size;
    int          cyc;
  } launch_t;

  launch_t lq[$];
  int      dq[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      rd_delay = 1;
  int      wr_delay = 1;
  int      rd_cnt = 0;
  int      wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Engine model: one done pulse per engine, rd_delay/wr_delay cycles after rd_start.
  initial forever begin
    @(negedge aclk);
    rd_done = 1'b0;
    wr_done = 1'b0;
    if (areset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) rd_done = 1'b1;
      end
      if (wr_cnt != 0) begin
        wr_cnt--;
        if (wr_cnt == 0) wr_done = 1'b1;
      end
      if (rd_start) begin
        rd_cnt = rd_delay;
        wr_cnt = wr_delay;
      end
    end
  end

  // Monitor: every launch and every ap_done must match the head of its queue.
  initial forever begin
    @(negedge aclk);
    if (!areset) begin
      if (rd_start || wr_start) begin
        if (lq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_launch: got rd_start=%b wr_start=%b at cycle %0d expected none", rd_start, wr_start, cyc);
        end else begin
          launch_t e;
          e = lq.pop_front();
          chk("rd_start", 64'(rd_start), 64'd1);
          chk("wr_start", 64'(wr_start), 64'd1);
          chk("rd_addr", rd_addr, e.rd);
          chk("wr_addr", wr_addr, e.wr);
          chk("rd_size", 64'(rd_size), 64'(e.size));
          chk("wr_size", 64'(wr_size), 64'(e.size));
          if (e.cyc >= 0) chk("launch_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (ap_done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got ap_done=1 at cycle %0d expected none", cyc);
        end else begin
          int ec;
          ec = dq.pop_front();
          if (ec >= 0) chk("done_cycle", 64'(cyc), 64'(ec));
          chk("ap_idle_in_done", 64'(ap_idle), 64'd0);
        end
      end
    end
  end

  task automatic run(input logic [31:0] size, input logic [31:0] passes,
                     input logic [63:0] p0, input logic [63:0] p1,
                     input int rdd, input int wrd, input int hold);
    bit got;
    int c;
    @(negedge aclk);
    c = cyc;
    scalar00 = size; scalar01 = passes; axi00_ptr0 = p0; axi01_ptr0 = p1;
    rd_delay = rdd; wr_delay = wrd;
    if (size == 0 || passes == 0) begin
      dq.push_back(c + 1);
    end else begin
      for (int i = 0; i < int'(passes); i++) begin
        launch_t e;
        e.rd = p0 + 64'(size) * 64'(i);
        e.wr = p1 + 64'(size) * 64'(i);
        e.size = size;
        e.cyc = (i == 0) ? c + 1 : -1;
        lq.push_back(e);
      end
      dq.push_back((passes == 1) ? c + 2 + ((rdd > wrd) ? rdd : wrd) : -1);
    end
    ap_start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      if (i == 2) begin
        scalar00 = 32'hDEAD_BEEF; scalar01 = 32'd7;
        axi00_ptr0 = 64'h5555_0000; axi01_ptr0 = 64'h6666_0000;
      end
      if (ap_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL run_timeout: got no ap_done expected ap_done within 2000 cycles");
    end
    repeat (hold) @(negedge aclk);
    ap_start = 1'b0;
    repeat (3) @(negedge aclk);
    chk("ap_idle_after_run", 64'(ap_idle), 64'd1);
    chk("launch_queue_empty", 64'(lq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge aclk);
    chk("rst_ap_idle", 64'(ap_idle), 64'd1);
    chk("rst_ap_done", 64'(ap_done), 64'd0);
    chk("rst_rd_start", 64'(rd_start), 64'd0);
    chk("rst_wr_start", 64'(wr_start), 64'd0);
    chk("rst_rd_addr", rd_addr, 64'd0);
    chk("rst_wr_addr", wr_addr, 64'd0);
    chk("rst_rd_size", 64'(rd_size), 64'd0);
    chk("rst_wr_size", 64'(wr_size), 64'd0);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    // Single pass, level held after completion must not relaunch.
    run(32'd64, 32'd1, 64'h1000, 64'h2000, 5, 5, 10);
`ifdef HARDCLOUD_KERNEL_CYCLE_COUNT_EN
    chk("cycle_count", cycle_count, 64'd7);
`endif
    run(32'h100, 32'd3, 64'h1000, 64'h2000, 3, 4, 0);
    run(32'h20, 32'd2, 64'h8000, 64'h9000, 3, 3, 0);
    run(32'h20, 32'd2, 64'h8000, 64'h9000, 6, 2, 0);
    run(32'h20, 32'd2, 64'h8000, 64'h9000, 2, 6, 0);
    run(32'd64, 32'd0, 64'h1000, 64'h2000, 1, 1, 0);
    run(32'd0, 32'd4, 64'h1000, 64'h2000, 1, 1, 0);
    run(32'h80, 32'd2, 64'hFFFF_FFFF_FFFF_FF80, 64'h2000, 2, 3, 0);

    // Reset in WAIT after the read completion: no ap_done, clean restart.
    @(negedge aclk);
    begin
      launch_t e;
      e.rd = 64'h3000; e.wr = 64'h4000; e.size = 32'h40; e.cyc = cyc + 1;
      lq.push_back(e);
    end
    scalar00 = 32'h40; scalar01 = 32'd2; axi00_ptr0 = 64'h3000; axi01_ptr0 = 64'h4000;
    rd_delay = 2; wr_delay = 20;
    ap_start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (rd_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rd_done_before_reset", 64'(seen), 64'd1);
    @(negedge aclk);
    areset = 1'b1;
    ap_start = 1'b0;
    @(negedge aclk);
    chk("mid_rst_ap_idle", 64'(ap_idle), 64'd1);
    chk("mid_rst_rd_addr", rd_addr, 64'd0);
    chk("mid_rst_ap_done", 64'(ap_done), 64'd0);
    areset = 1'b0;
    repeat (30) @(negedge aclk);
    chk("reset_run_queue_empty", 64'(lq.size()), 64'd0);
    run(32'h40, 32'd2, 64'h3000, 64'h4000, 4, 1, 0);

    repeat (5) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running expected completion");
    $fatal(1, "timeout");
  end

endmodule
